// File: rtl/pc_sequencer_if.sv
// Bus between the program-counter sequencer and its surroundings.
// Fetch/control drive the select and targets; the sequencer returns the PC and stack status.
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic [2:0]       sel;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] reg_target;
    logic             call;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] next_pc;
    logic             halted;
    logic             stack_empty;
    logic             stack_full;
    logic             stack_ovf;
    logic             stack_unf;

    modport master (
        output stall, sel, branch_target, jump_target, reg_target, call,
        input  pc, next_pc, halted, stack_empty, stack_full, stack_ovf, stack_unf
    );

    modport slave (
        input  stall, sel, branch_target, jump_target, reg_target, call,
        output pc, next_pc, halted, stack_empty, stack_full, stack_ovf, stack_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter register with next-PC source select, RUN/HALT control,
// stall, and a circular hardware return-address stack.
module pc_sequencer #(
    parameter int          WIDTH       = 16,
    parameter int          STACK_DEPTH = 4,
    parameter int unsigned RESET_VEC   = 0,
    parameter int unsigned INT_VEC     = 22,
    parameter int unsigned TRAP_VEC    = 12,
    parameter int unsigned HALT_VEC    = 200
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(STACK_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             ovf_q;
    logic             ovf_next;
    logic             unf_q;
    logic             unf_next;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             empty;
    logic             full;

    assign seq   = pc_q + WIDTH'(1);
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!bus.stall) begin
            case (state)
                RUN:  if (bus.sel == 3'd6) state_next = HALT;
                HALT: if (bus.sel == 3'd4) state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    // top always indexes the newest entry; a return-then-call rewrites that slot in place.
    always_comb begin
        pc_next    = pc_q;
        top_next   = top;
        count_next = count;
        ovf_next   = ovf_q;
        unf_next   = unf_q;
        wr_en      = 1'b0;
        wr_idx     = top;
        if (!bus.stall) begin
            if (state == HALT) begin
                if (bus.sel == 3'd4) pc_next = WIDTH'(INT_VEC);
            end else begin
                case (bus.sel)
                    3'd0: pc_next = seq;
                    3'd1: pc_next = bus.branch_target;
                    3'd2: pc_next = bus.jump_target;
                    3'd3: pc_next = bus.reg_target;
                    3'd4: pc_next = WIDTH'(INT_VEC);
                    3'd5: pc_next = WIDTH'(TRAP_VEC);
                    3'd6: pc_next = WIDTH'(HALT_VEC);
                    3'd7: begin
                        if (empty) begin
                            pc_next  = WIDTH'(TRAP_VEC);
                            unf_next = 1'b1;
                        end else begin
                            pc_next = stack_mem[top];
                        end
                    end
                    default: pc_next = seq;
                endcase
                if (bus.sel == 3'd7 && !empty) begin
                    if (bus.call) begin
                        wr_en  = 1'b1;
                        wr_idx = top;
                    end else begin
                        top_next   = top - PTR_W'(1);
                        count_next = count - CNT_W'(1);
                    end
                end else if (bus.call) begin
                    wr_en    = 1'b1;
                    wr_idx   = top + PTR_W'(1);
                    top_next = top + PTR_W'(1);
                    if (full) ovf_next = 1'b1;
                    else      count_next = count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= WIDTH'(RESET_VEC);
            top   <= '0;
            count <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_next;
            top   <= top_next;
            count <= count_next;
            ovf_q <= ovf_next;
            unf_q <= unf_next;
        end
    end

    // Entries need no reset: an empty count makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) stack_mem[wr_idx] <= seq;
    end

    assign bus.pc          = pc_q;
    assign bus.next_pc     = pc_next;
    assign bus.halted      = (state == HALT);
    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;
    assign bus.stack_ovf   = ovf_q;
    assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a queue-based model of the PC and return stack.
module tb_pc_sequencer;
    localparam logic [15:0] RESET_VEC = 16'd0;
    localparam logic [15:0] INT_VEC   = 16'd22;
    localparam logic [15:0] TRAP_VEC  = 16'd12;
    localparam logic [15:0] HALT_VEC  = 16'd200;
    localparam int          DEPTH     = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(16)) bus ();

    pc_sequencer #(
        .WIDTH(16), .STACK_DEPTH(DEPTH), .RESET_VEC(0),
        .INT_VEC(22), .TRAP_VEC(12), .HALT_VEC(200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] m_pc;
    logic [15:0] exp_next;
    bit          m_halt;
    bit          m_ovf;
    bit          m_unf;
    logic [15:0] m_stack [$];

    task automatic model_reset();
        m_pc   = RESET_VEC;
        m_halt = 0;
        m_ovf  = 0;
        m_unf  = 0;
        m_stack.delete();
    endtask

    // Drive one cycle of inputs and advance the model to the state expected after the next edge.
    task automatic applyStimulus(input bit st, input logic [2:0] s, input bit c,
                                 input logic [15:0] bt, input logic [15:0] jt, input logic [15:0] rt);
        logic [15:0] seqv;
        bus.stall = st; bus.sel = s; bus.call = c;
        bus.branch_target = bt; bus.jump_target = jt; bus.reg_target = rt;
        seqv     = m_pc + 16'd1;
        exp_next = m_pc;
        if (!st) begin
            if (m_halt) begin
                if (s == 3'd4) begin exp_next = INT_VEC; m_halt = 0; end
            end else begin
                case (s)
                    3'd0: exp_next = seqv;
                    3'd1: exp_next = bt;
                    3'd2: exp_next = jt;
                    3'd3: exp_next = rt;
                    3'd4: exp_next = INT_VEC;
                    3'd5: exp_next = TRAP_VEC;
                    3'd6: begin exp_next = HALT_VEC; m_halt = 1; end
                    default: begin
                        if (m_stack.size() == 0) begin exp_next = TRAP_VEC; m_unf = 1; end
                        else exp_next = m_stack.pop_back();
                    end
                endcase
                if (c) begin
                    m_stack.push_back(seqv);
                    if (m_stack.size() > DEPTH) begin
                        void'(m_stack.pop_front());
                        m_ovf = 1;
                    end
                end
            end
        end
        m_pc = exp_next;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 0; bus.sel = 0; bus.call = 0;
        bus.branch_target = 0; bus.jump_target = 0; bus.reg_target = 0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.pc !== RESET_VEC) begin n_fail++; $display("[TB] FAIL reset_pc: got %h want %h", bus.pc, RESET_VEC); end
        n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_halted: got %b want 0", bus.halted); end
        n_cmp++; if (bus.stack_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b want 1", bus.stack_empty); end
        n_cmp++; if ({bus.stack_full, bus.stack_ovf, bus.stack_unf} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 000", {bus.stack_full, bus.stack_ovf, bus.stack_unf}); end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 3'd0, 0, 16'h0, 16'h0, 16'h0);
            tick();
            n_cmp++; if (bus.pc !== 16'(i)) begin n_fail++; $display("[TB] FAIL seq_pc%0d: got %h want %h", i, bus.pc, 16'(i)); end
        end
        n_cmp++; if ({bus.halted, bus.stack_full, bus.stack_ovf, bus.stack_unf, bus.stack_empty} !== 5'b00001) begin n_fail++; $display("[TB] FAIL seq_flags: got %b want 00001", {bus.halted, bus.stack_full, bus.stack_ovf, bus.stack_unf, bus.stack_empty}); end
    endtask

    task automatic test_sources_wrap();
        applyStimulus(0, 3'd3, 0, 16'h0, 16'h0, 16'hFFFF);
        n_cmp++; if (bus.next_pc !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL reg_next_pc: got %h want ffff", bus.next_pc); end
        tick();
        n_cmp++; if (bus.pc !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL reg_pc: got %h want ffff", bus.pc); end
        applyStimulus(0, 3'd0, 0, 16'h0, 16'h0, 16'h0);
        tick();
        n_cmp++; if (bus.pc !== 16'h0000) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h want 0000", bus.pc); end
        applyStimulus(0, 3'd1, 0, 16'h0040, 16'h0, 16'h0);
        tick();
        n_cmp++; if (bus.pc !== 16'h0040) begin n_fail++; $display("[TB] FAIL branch_pc: got %h want 0040", bus.pc); end
        applyStimulus(0, 3'd2, 0, 16'h0, 16'h1234, 16'h0);
        tick();
        n_cmp++; if (bus.pc !== 16'h1234) begin n_fail++; $display("[TB] FAIL jump_pc: got %h want 1234", bus.pc); end
    endtask

    task automatic test_call_return();
        applyStimulus(0, 3'd2, 0, 16'h0, 16'h0010, 16'h0);
        tick();
        applyStimulus(0, 3'd2, 1, 16'h0, 16'h0100, 16'h0);
        tick();
        n_cmp++; if (bus.pc !== 16'h0100) begin n_fail++; $display("[TB] FAIL call_pc: got %h want 0100", bus.pc); end
        n_cmp++; if (bus.stack_empty !== 1'b0) begin n_fail++; $display("[TB] FAIL call_empty: got %b want 0", bus.stack_empty); end
        applyStimulus(0, 3'd7, 0, 16'h0, 16'h0, 16'h0);
        n_cmp++; if (bus.next_pc !== 16'h0011) begin n_fail++; $display("[TB] FAIL ret_next_pc: got %h want 0011", bus.next_pc); end
        tick();
        n_cmp++; if (bus.pc !== 16'h0011) begin n_fail++; $display("[TB] FAIL ret_pc: got %h want 0011", bus.pc); end
        n_cmp++; if (bus.stack_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL ret_empty: got %b want 1", bus.stack_empty); end
    endtask

    task automatic test_ovf_unf();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 3'd2, 1, 16'h0, 16'(16'h0200 + i * 16), 16'h0);
            tick();
            n_cmp++; if (bus.stack_full !== logic'(m_stack.size() == DEPTH)) begin n_fail++; $display("[TB] FAIL call%0d_full: got %b want %b", i, bus.stack_full, m_stack.size() == DEPTH); end
        end
        n_cmp++; if (bus.stack_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_flag: got %b want 1", bus.stack_ovf); end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 3'd7, 0, 16'h0, 16'h0, 16'h0);
            tick();
            n_cmp++; if (bus.pc !== m_pc) begin n_fail++; $display("[TB] FAIL ret%0d_pc: got %h want %h", i, bus.pc, m_pc); end
        end
        n_cmp++; if (bus.stack_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL drained_empty: got %b want 1", bus.stack_empty); end
        applyStimulus(0, 3'd7, 0, 16'h0, 16'h0, 16'h0);
        tick();
        n_cmp++; if (bus.pc !== TRAP_VEC) begin n_fail++; $display("[TB] FAIL unf_pc: got %h want %h", bus.pc, TRAP_VEC); end
        n_cmp++; if (bus.stack_unf !== 1'b1) begin n_fail++; $display("[TB] FAIL unf_flag: got %b want 1", bus.stack_unf); end
    endtask

    task automatic test_halt_stall();
        logic [2:0] held_sel [4] = '{3'd0, 3'd1, 3'd7, 3'd7};
        applyStimulus(0, 3'd6, 0, 16'h0, 16'h0, 16'h0);
        tick();
        n_cmp++; if (bus.pc !== HALT_VEC) begin n_fail++; $display("[TB] FAIL halt_pc: got %h want %h", bus.pc, HALT_VEC); end
        n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_flag: got %b want 1", bus.halted); end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, held_sel[i], 1, 16'h0055, 16'h0066, 16'h0077);
            n_cmp++; if (bus.next_pc !== HALT_VEC) begin n_fail++; $display("[TB] FAIL halt_next%0d: got %h want %h", i, bus.next_pc, HALT_VEC); end
            tick();
            n_cmp++; if (bus.pc !== HALT_VEC) begin n_fail++; $display("[TB] FAIL halt_hold%0d: got %h want %h", i, bus.pc, HALT_VEC); end
        end
        n_cmp++; if (bus.stack_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_call_ignored: got %b want 1", bus.stack_empty); end
        applyStimulus(0, 3'd4, 0, 16'h0, 16'h0, 16'h0);
        tick();
        n_cmp++; if (bus.pc !== INT_VEC) begin n_fail++; $display("[TB] FAIL int_pc: got %h want %h", bus.pc, INT_VEC); end
        n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("[TB] FAIL int_halted: got %b want 0", bus.halted); end
        applyStimulus(1, 3'd1, 1, 16'h0999, 16'h0, 16'h0);
        n_cmp++; if (bus.next_pc !== INT_VEC) begin n_fail++; $display("[TB] FAIL stall_next: got %h want %h", bus.next_pc, INT_VEC); end
        tick();
        n_cmp++; if (bus.pc !== INT_VEC) begin n_fail++; $display("[TB] FAIL stall_pc: got %h want %h", bus.pc, INT_VEC); end
        n_cmp++; if (bus.stack_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_call_ignored: got %b want 1", bus.stack_empty); end
    endtask

    task automatic test_async_reset();
        applyStimulus(0, 3'd0, 1, 16'h0, 16'h0, 16'h0);
        tick();
        applyStimulus(0, 3'd0, 1, 16'h0, 16'h0, 16'h0);
        tick();
        applyStimulus(0, 3'd6, 0, 16'h0, 16'h0, 16'h0);
        tick();
        n_cmp++; if ({bus.halted, bus.stack_empty, bus.stack_ovf, bus.stack_unf} !== 4'b1011) begin n_fail++; $display("[TB] FAIL pre_reset_state: got %b want 1011", {bus.halted, bus.stack_empty, bus.stack_ovf, bus.stack_unf}); end
        #1;
        bus.sel = 3'd0; bus.call = 0; bus.stall = 0;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.pc !== RESET_VEC) begin n_fail++; $display("[TB] FAIL async_pc: got %h want %h", bus.pc, RESET_VEC); end
        n_cmp++; if ({bus.halted, bus.stack_empty, bus.stack_full, bus.stack_ovf, bus.stack_unf} !== 5'b01000) begin n_fail++; $display("[TB] FAIL async_flags: got %b want 01000", {bus.halted, bus.stack_empty, bus.stack_full, bus.stack_ovf, bus.stack_unf}); end
        rst = 1'b0;
        model_reset();
        applyStimulus(0, 3'd0, 0, 16'h0, 16'h0, 16'h0);
        tick();
        n_cmp++; if (bus.pc !== 16'h0001) begin n_fail++; $display("[TB] FAIL post_reset_pc: got %h want 0001", bus.pc); end
    endtask

    task automatic test_random();
        bit          st;
        bit          c;
        logic [2:0]  s;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 2) == 0);
            s  = 3'($urandom_range(0, 7));
            applyStimulus(st, s, c, 16'($urandom), 16'($urandom), 16'($urandom));
            n_cmp++; if (bus.next_pc !== exp_next) begin n_fail++; $display("[TB] FAIL rnd%0d_next: got %h want %h", i, bus.next_pc, exp_next); end
            tick();
            n_cmp++; if (bus.pc !== m_pc) begin n_fail++; $display("[TB] FAIL rnd%0d_pc: got %h want %h", i, bus.pc, m_pc); end
            n_cmp++; if (bus.halted !== logic'(m_halt)) begin n_fail++; $display("[TB] FAIL rnd%0d_halted: got %b want %b", i, bus.halted, m_halt); end
            n_cmp++; if ({bus.stack_empty, bus.stack_full} !== {logic'(m_stack.size() == 0), logic'(m_stack.size() == DEPTH)}) begin n_fail++; $display("[TB] FAIL rnd%0d_level: got %b%b want size %0d", i, bus.stack_empty, bus.stack_full, m_stack.size()); end
            n_cmp++; if ({bus.stack_ovf, bus.stack_unf} !== {logic'(m_ovf), logic'(m_unf)}) begin n_fail++; $display("[TB] FAIL rnd%0d_sticky: got %b%b want %b%b", i, bus.stack_ovf, bus.stack_unf, m_ovf, m_unf); end
        end
    endtask

    initial begin
        test_reset();
        test_sources_wrap();
        test_call_return();
        test_ovf_unf();
        test_halt_stall();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
